// File: rtl/exc_code_pipe.sv
// Exception-code carrier from D-stage exit through STAGES stages, with EPC/cause/BD latching until eret.
// Optional feature macro: EXC_PIPE_INT_EN (external interrupt taken at the last stage while IDLE).
module exc_code_pipe #(
    parameter int unsigned           STAGES = 3,
    parameter int unsigned           CODE_W = 5,
    parameter int unsigned           PC_W   = 32,
    parameter logic [CODE_W-1:0]     NO_EXC = CODE_W'(31)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [CODE_W-1:0]        in_code,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     in_bd,
    input  logic [STAGES*CODE_W-1:0] stage_code,
    input  logic                     eret,
    input  logic                     int_req,
    output logic                     exc_req,
    output logic [CODE_W-1:0]        exc_code,
    output logic [PC_W-1:0]          epc,
    output logic                     exc_bd,
    output logic                     exl
);

    localparam int unsigned LAST = STAGES - 1;

    typedef enum logic {IDLE, TAKEN} state_t;

    state_t             state_q, state_d;
    logic               valid_q [STAGES];
    logic [CODE_W-1:0]  code_q  [STAGES];
    logic [PC_W-1:0]    pc_q    [STAGES];
    logic               bd_q    [STAGES];
    logic [CODE_W-1:0]  merged  [STAGES];
    logic [CODE_W-1:0]  take_code;
    logic               flush_all;

    // A code already carried from an earlier stage has priority over the local one.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            merged[k] = NO_EXC;
            if (valid_q[k])
                merged[k] = (code_q[k] != NO_EXC) ? code_q[k] : stage_code[k*CODE_W +: CODE_W];
        end
    end

    always_comb begin
        exc_req   = valid_q[LAST] && (merged[LAST] != NO_EXC) && !stall;
        take_code = merged[LAST];
`ifdef EXC_PIPE_INT_EN
        if ((state_q == IDLE) && int_req && valid_q[LAST] && !stall) begin
            exc_req   = 1'b1;
            take_code = '0;
        end
`endif
    end

`ifndef EXC_PIPE_INT_EN
    logic unused_int_req;
    assign unused_int_req = int_req;
`endif

    assign flush_all = flush || exc_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                code_q[k]  <= NO_EXC;
                pc_q[k]    <= '0;
                bd_q[k]    <= 1'b0;
            end
        end else if (flush_all) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                code_q[k]  <= NO_EXC;
            end
        end else if (!stall) begin
            valid_q[0] <= in_valid;
            code_q[0]  <= in_code;
            pc_q[0]    <= in_pc;
            bd_q[0]    <= in_bd;
            for (int unsigned k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                code_q[k]  <= merged[k-1];
                pc_q[k]    <= pc_q[k-1];
                bd_q[k]    <= bd_q[k-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (exc_req)
            state_d = TAKEN;
        else if ((state_q == TAKEN) && eret && valid_q[LAST] && !stall)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            exc_code <= NO_EXC;
            epc      <= '0;
            exc_bd   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (exc_req) begin
                exc_code <= take_code;
                // EPC and BD are frozen once EXL is set; only the cause tracks nested exceptions.
                if (state_q == IDLE) begin
                    epc    <= bd_q[LAST] ? (pc_q[LAST] - PC_W'(4)) : pc_q[LAST];
                    exc_bd <= bd_q[LAST];
                end
            end
        end
    end

    assign exl = (state_q == TAKEN);

endmodule

// File: tb/tb_exc_code_pipe.sv
// Self-checking bench for exc_code_pipe: directed scenarios then random traffic against an instruction-slot model.
module tb_exc_code_pipe;

    localparam int S  = 3;
    localparam int NO = 31;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, in_valid, in_bd, eret, int_req;
    logic [4:0]  in_code;
    logic [31:0] in_pc;
    logic [14:0] stage_code;
    logic        exc_req, exc_bd, exl;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    exc_code_pipe #(.STAGES(S), .CODE_W(5), .PC_W(32), .NO_EXC(5'd31)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_code(in_code), .in_pc(in_pc), .in_bd(in_bd),
        .stage_code(stage_code), .eret(eret), .int_req(int_req),
        .exc_req(exc_req), .exc_code(exc_code), .epc(epc), .exc_bd(exc_bd), .exl(exl)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: one record per pipeline slot, slot 0 = E; handler state as plain variables.
    bit          s_v [S];
    int          s_c [S];
    int unsigned s_pc[S];
    bit          s_bd[S];
    bit          in_handler;
    int          m_code;
    int unsigned m_epc;
    bit          m_bd;
    logic        seen_req;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int earliest(input int k, input logic [14:0] sc);
        int local_c;
        local_c = int'(sc >> (5*k)) & 31;
        if (!s_v[k]) return NO;
        if (s_c[k] != NO) return s_c[k];
        return local_c;
    endfunction

    function automatic logic [14:0] sc_at(input int k, input int code);
        logic [14:0] v;
        v = '1;
        v[5*k +: 5] = 5'(code);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < S; k++) begin
            s_v[k] = 0; s_c[k] = NO; s_pc[k] = 0; s_bd[k] = 0;
        end
        in_handler = 0; m_code = NO; m_epc = 0; m_bd = 0;
    endtask

    task automatic step(input bit iv, input int ic, input int unsigned ipc, input bit ibd,
                        input logic [14:0] sc, input bit stl, input bit fl, input bit er, input bit ir);
        bit          take;
        int          tcode;
        int          nc[S];
        in_valid = iv; in_code = 5'(ic); in_pc = ipc; in_bd = ibd;
        stage_code = sc; stall = stl; flush = fl; eret = er; int_req = ir;
        #4;
        tcode = earliest(S-1, sc);
        take  = s_v[S-1] && (tcode != NO) && !stl;
`ifdef EXC_PIPE_INT_EN
        if (!in_handler && ir && s_v[S-1] && !stl) begin
            take = 1; tcode = 0;
        end
`endif
        seen_req = exc_req;
        check("exc_req", exc_req, 32'(take));
        for (int k = 0; k < S; k++) nc[k] = earliest(k, sc);
        @(posedge clk);
        if (take) begin
            m_code = tcode;
            if (!in_handler) begin
                m_epc = s_bd[S-1] ? s_pc[S-1] - 32'd4 : s_pc[S-1];
                m_bd  = s_bd[S-1];
            end
            in_handler = 1;
        end else if (in_handler && er && s_v[S-1] && !stl) begin
            in_handler = 0;
        end
        if (fl || take) begin
            for (int k = 0; k < S; k++) begin s_v[k] = 0; s_c[k] = NO; end
        end else if (!stl) begin
            for (int k = S-1; k > 0; k--) begin
                s_v[k] = s_v[k-1]; s_c[k] = nc[k-1]; s_pc[k] = s_pc[k-1]; s_bd[k] = s_bd[k-1];
            end
            s_v[0] = iv; s_c[0] = ic; s_pc[0] = ipc; s_bd[0] = ibd;
        end
        #1;
        check("exc_code", exc_code, 32'(m_code));
        check("epc", epc, m_epc);
        check("exc_bd", exc_bd, 32'(m_bd));
        check("exl", exl, 32'(in_handler));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, NO, 0, 0, '1, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0; stall = 0; flush = 0; in_valid = 0; in_code = 5'd31; in_pc = 0;
        in_bd = 0; stage_code = '1; eret = 0; int_req = 0;
        model_reset();
        @(posedge clk); #1;
        check("rst_exc_code", exc_code, 32'd31);
        check("rst_epc", epc, 0);
        check("rst_exl", exl, 0);
        check("rst_exc_req", exc_req, 0);
        reset = 1'b1;

        // Ov at E propagates to W
        step(1, NO, 32'h100, 0, '1, 0, 0, 0, 0);
        step(0, NO, 0, 0, sc_at(0, 12), 0, 0, 0, 0);
        step(0, NO, 0, 0, '1, 0, 0, 0, 0);
        step(0, NO, 0, 0, '1, 0, 0, 0, 0);
        check("t1_req", seen_req, 1);
        check("t1_code", exc_code, 12);
        check("t1_epc", epc, 32'h100);
        check("t1_exl", exl, 1);
        idle(1);
        check("t1_flushed", seen_req, 0);

        // Earliest code wins; EPC frozen while EXL
        step(1, 10, 32'h200, 0, '1, 0, 0, 0, 0);
        step(0, NO, 0, 0, sc_at(0, 12), 0, 0, 0, 0);
        idle(2);
        check("t2_code", exc_code, 10);
        check("t2_epc_held", epc, 32'h100);

        step(1, NO, 32'h300, 0, '1, 0, 0, 0, 0);
        idle(2);
        step(0, NO, 0, 0, '1, 0, 0, 1, 0);
        check("t5_eret_exl", exl, 0);

        // Branch-delay EPC, then nested exception
        step(1, NO, 32'h3008, 1, '1, 0, 0, 0, 0);
        step(0, NO, 0, 0, '1, 0, 0, 0, 0);
        step(0, NO, 0, 0, sc_at(1, 4), 0, 0, 0, 0);
        idle(1);
        check("t3_code", exc_code, 4);
        check("t3_epc", epc, 32'h3004);
        check("t3_bd", exc_bd, 1);
        step(1, NO, 32'h4000, 0, '1, 0, 0, 0, 0);
        step(0, NO, 0, 0, sc_at(0, 12), 0, 0, 0, 0);
        idle(2);
        check("t3_nested_code", exc_code, 12);
        check("t3_nested_epc", epc, 32'h3004);

        // eret and exc_req together
        step(1, 12, 32'h500, 0, '1, 0, 0, 0, 0);
        idle(2);
        step(0, NO, 0, 0, '1, 0, 0, 1, 0);
        check("t5_both_req", seen_req, 1);
        check("t5_both_exl", exl, 1);

        // Stall with exception at last stage
        step(1, 13, 32'h600, 0, '1, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            step(0, NO, 0, 0, '1, 1, 0, 0, 0);
            check("t4_stalled_req", seen_req, 0);
        end
        step(0, NO, 0, 0, '1, 0, 0, 0, 0);
        check("t4_release_req", seen_req, 1);
        check("t4_code", exc_code, 13);

        step(1, NO, 32'h700, 0, '1, 0, 0, 0, 0);
        idle(2);
        step(0, NO, 0, 0, '1, 0, 0, 1, 0);
        check("t5_exit", exl, 0);
        step(1, NO, 32'h740, 0, '1, 0, 0, 0, 0);
        idle(2);
        step(0, NO, 0, 0, '1, 0, 0, 1, 0);
        check("t5_idle_eret_exl", exl, 0);
        check("t5_idle_eret_code", exc_code, 13);

        // Interrupt versus Syscall at last stage
        step(1, 8, 32'h800, 0, '1, 0, 0, 0, 0);
        idle(2);
        step(0, NO, 0, 0, '1, 0, 0, 0, 1);
`ifdef EXC_PIPE_INT_EN
        check("t6_code", exc_code, 0);
`else
        check("t6_code", exc_code, 8);
`endif
        check("t6_epc", epc, 32'h800);

        for (int i = 0; i < 400; i++) begin
            logic [14:0] sc;
            sc = '1;
            for (int k = 0; k < S; k++)
                if ($urandom_range(7) == 0) sc[5*k +: 5] = 5'($urandom_range(30));
            step(bit'($urandom_range(3) != 0),
                 ($urandom_range(9) == 0) ? int'($urandom_range(30)) : NO,
                 $urandom & 32'hFFFF_FFFC, bit'($urandom_range(1)), sc,
                 $urandom_range(4) == 0, $urandom_range(19) == 0,
                 $urandom_range(4) == 0, $urandom_range(9) == 0);
        end

        // Asynchronous reset between clock edges
        step(1, 12, 32'h900, 1, '1, 0, 0, 0, 0);
        step(1, NO, 32'h904, 0, '1, 0, 0, 0, 0);
        idle(1);
        reset = 1'b0;
        #1;
        check("arst_exc_code", exc_code, 32'd31);
        check("arst_epc", epc, 0);
        check("arst_bd", exc_bd, 0);
        check("arst_exl", exl, 0);
        check("arst_exc_req", exc_req, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        step(1, 6, 32'hA00, 0, '1, 0, 0, 0, 0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
